mmul_cond_sub: RTL and testbench
================================

Name: mmul_cond_sub

Overview:
- Word-serial conditional-subtract stage directly downstream of the 256-bit modular-multiply C register.
- Consumes the 16 C words, least-significant word first, plus the b256 carry bit produced after the 1-bit left shift.
- Consumes the matching 16 modulus words M in lockstep.
- Emits C' = (C >= M) ? C - M : C as 16 words, where C is the 257-bit value {b256, C[255:0]} and C < 2M is guaranteed upstream.

Parameters:
- W, 16, word width in bits.
- NW, 16, words per operand (operand = W*NW = 256 bits).
- CW, 4, word counter width (log2 NW).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset; clears all state on the rising edge when high.
- start  input  1  begin a transaction; accepted only in IDLE.
- in_valid  input  1  c_word/m_word/c_b256 valid this cycle.
- in_ready  output  1  block accepts an input word this cycle.
- c_word  input  W  C word, LSW first.
- m_word  input  W  M word, same index as c_word.
- c_b256  input  1  C bit 256; sampled only with word NW-1.
- out_valid  output  1  out_word valid.
- out_ready  input  1  downstream accepts out_word.
- out_word  output  W  result word, LSW first.
- out_last  output  1  high with word NW-1.
- sel_sub  output  1  1 = subtraction taken for the current result.
- busy  output  1  not in IDLE.
- done  output  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (clr=1 at clock edge, any state):
  - state=IDLE; word counter=0; borrow=0; b256 latch=0; sel_sub=0; done=0.
  - in_ready, out_valid, out_last and busy are 0 in IDLE.
  - The internal buffers are not cleared. out_word is forced to 0 whenever out_valid=0.
- FSM states: IDLE, LOAD, DECIDE, OUT.
- IDLE:
  - start=1 → LOAD; counter=0; borrow=0; sel_sub=0.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Input handshake = in_valid & in_ready. Each handshake:
    - {b, d} = {1'b0, c_word} - {1'b0, m_word} - borrow (17-bit result).
    - d_buf[cnt] <= d; c_buf[cnt] <= c_word; borrow <= b; cnt++.
  - in_valid=0 cycles stall with no state change.
  - Handshake at cnt=NW-1 also latches c_b256 → DECIDE; counter wraps to 0.
- DECIDE (exactly 1 cycle, in_ready=0):
  - sel_sub <= b256_latch | ~borrow.
  - → OUT.
- OUT:
  - out_valid=1.
  - out_word = sel_sub ? d_buf[cnt] : c_buf[cnt].
  - out_last = (cnt == NW-1).
  - Handshake = out_valid & out_ready, advances cnt.
  - out_ready=0 holds out_word, out_last and cnt stable.
  - Handshake with out_last=1 → IDLE; done=1 on the following cycle only.
- sel_sub holds its value from DECIDE until the next start or clr.
- Latency with no stalls:
  - start at cycle t → LOAD at t+1; 16 words accepted t+1..t+16.
  - DECIDE at t+17; first out_valid at t+18; out_last at t+33; done at t+34.
- Boundaries:
  - C == M: borrow=0 → sel_sub=1, all output words 0.
  - b256=1 forces subtraction regardless of the final borrow. The low 256 bits of C-M are correct modulo 2^256.
  - clr in the same cycle as start or as any handshake: clr wins, no word is stored.
  - Counter never exceeds NW-1.

Test Plan:
- C word0=0x0005, M word0=0x0003, all other words 0, b256=0 → out word0=0x0002, words1..15=0x0000, sel_sub=1, done at t+34.
- C word0=0x0002, M word0=0x0003, b256=0 → output equals C (word0=0x0002), sel_sub=0. Repeat with C=M=0x1234 in every word → all outputs 0x0000, sel_sub=1.
- Borrow chain: C word1=0x0001, word0=0x0000; M word0=0x0001 → out word0=0xFFFF, word1=0x0000, sel_sub=1.
- b256=1, C=0, M word0=0x0001 → all 16 words 0xFFFF, sel_sub=1; out_last only on the 16th word.
- Stalls: in_valid low 2 cycles after word 4; out_ready low 3 cycles on word 7 → word 7 held stable, no word dropped or duplicated, results match the no-stall run.
- clr at LOAD word 9 → next cycle busy=0, in_ready=0, out_valid=0; a fresh start with C=5, M=3 then yields word0=0x0002.

Source files
------------

// File: rtl/mmul_cond_sub.sv
// Word-serial conditional subtract after the modular-multiply C register.
// Buffers C and C-M word by word, then emits whichever is the reduced result.
module mmul_cond_sub #(
    parameter int W  = 16,
    parameter int NW = 16,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] c_word,
    input  logic [W-1:0] m_word,
    input  logic         c_b256,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_word,
    output logic         out_last,
    output logic         sel_sub,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DECIDE,
        OUT
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          borrow_q, borrow_d;
    logic          b256_q, b256_d;
    logic          sel_sub_q, sel_sub_d;
    logic          done_q, done_d;

    logic [W-1:0]  d_buf_q [NW];
    logic [W-1:0]  c_buf_q [NW];

    logic          in_hs;
    logic          out_hs;
    logic          cnt_last;
    logic [W:0]    sub_full;

    assign in_hs    = (state_q == LOAD) && in_valid;
    assign out_hs   = (state_q == OUT) && out_ready;
    assign cnt_last = (cnt_q == LAST_IDX);

    // The 17-bit result carries the borrow out of this word in its top bit.
    assign sub_full = {1'b0, c_word} - {1'b0, m_word} - {{W{1'b0}}, borrow_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        b256_d    = b256_q;
        sel_sub_d = sel_sub_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    borrow_d  = 1'b0;
                    b256_d    = 1'b0;
                    sel_sub_d = 1'b0;
                end
            end
            LOAD: begin
                if (in_hs) begin
                    borrow_d = sub_full[W];
                    if (cnt_last) begin
                        cnt_d   = '0;
                        b256_d  = c_b256;
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DECIDE: begin
                // A set bit 256 means C >= 2^256 > M, so subtract regardless of borrow.
                sel_sub_d = b256_q | ~borrow_q;
                state_d   = OUT;
            end
            OUT: begin
                if (out_hs) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            b256_q    <= 1'b0;
            sel_sub_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            b256_q    <= b256_d;
            sel_sub_q <= sel_sub_d;
            done_q    <= done_d;
        end
    end

    // Word buffers are deliberately left uncleared; clr only blocks the write.
    always_ff @(posedge clk) begin
        if (!clr && in_hs) begin
            d_buf_q[cnt_q] <= sub_full[W-1:0];
            c_buf_q[cnt_q] <= c_word;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign out_last  = out_valid && cnt_last;
    assign out_word  = out_valid ? (sel_sub_q ? d_buf_q[cnt_q] : c_buf_q[cnt_q]) : '0;
    assign sel_sub   = sel_sub_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_mmul_cond_sub.sv
// Directed bench for mmul_cond_sub: hand-computed vectors, stalls, latency and clr abort.
module tb_mmul_cond_sub;

    logic        clk;
    logic        clr;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] c_word;
    logic [15:0] m_word;
    logic        c_b256;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_last;
    logic        sel_sub;
    logic        busy;
    logic        done;

    int tests;
    int fails;
    int cycleCount;

    logic [15:0] cVec   [16];
    logic [15:0] mVec   [16];
    logic [15:0] expVec [16];

    mmul_cond_sub #(.W(16), .NW(16), .CW(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_word    (c_word),
        .m_word    (m_word),
        .c_b256    (c_b256),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .sel_sub   (sel_sub),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearVecs();
        for (int k = 0; k < 16; k++) begin
            cVec[k]   = 16'h0000;
            mVec[k]   = 16'h0000;
            expVec[k] = 16'h0000;
        end
    endtask

    // Runs one transaction; abortAt >= 0 raises clr while word abortAt is offered.
    task automatic applyStimulus(input string name, input logic b256,
                                 input int inStallAt, input int inStallLen,
                                 input int outStallAt, input int outStallLen,
                                 input logic expSel, input int abortAt);
        int i;
        int j;
        int guard;
        int tStart;
        int inLeft;
        int outLeft;
        int lastBad;
        int lat;
        logic        heldSeen;
        logic [15:0] heldVal;
        logic [15:0] resVec [16];
        logic        selSeen;

        inLeft   = inStallLen;
        outLeft  = outStallLen;
        lastBad  = 0;
        heldSeen = 1'b0;
        heldVal  = 16'h0000;
        selSeen  = 1'b0;
        for (int k = 0; k < 16; k++) resVec[k] = 16'h0000;

        @(negedge clk);
        start  = 1'b1;
        tStart = cycleCount;
        @(negedge clk);
        start = 1'b0;

        i = 0;
        guard = 0;
        while (i < 16 && guard < 100) begin
            if (i == inStallAt && inLeft > 0) begin
                in_valid = 1'b0;
                inLeft--;
            end else begin
                in_valid = 1'b1;
                c_word   = cVec[i];
                m_word   = mVec[i];
                c_b256   = (i == 15) ? b256 : 1'b0;
            end
            if (i == abortAt) begin
                clr = 1'b1;
                @(negedge clk);
                clr      = 1'b0;
                in_valid = 1'b0;
                checkOutput({name, ":busy_after_clr"}, 32'(busy), 32'd0);
                checkOutput({name, ":in_ready_after_clr"}, 32'(in_ready), 32'd0);
                checkOutput({name, ":out_valid_after_clr"}, 32'(out_valid), 32'd0);
                return;
            end
            if (in_valid && in_ready) i++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        c_b256   = 1'b0;
        checkOutput({name, ":words_accepted"}, 32'(i), 32'd16);

        j = 0;
        guard = 0;
        while (j < 16 && guard < 100) begin
            out_ready = 1'b1;
            if (out_valid) begin
                if (out_last !== (j == 15)) lastBad++;
                if (j == outStallAt && outLeft > 0) begin
                    out_ready = 1'b0;
                    outLeft--;
                    if (!heldSeen) heldVal = out_word;
                    heldSeen = 1'b1;
                end else begin
                    if (j == outStallAt && heldSeen)
                        checkOutput({name, ":held_word"}, 32'(out_word), 32'(heldVal));
                    resVec[j] = out_word;
                    selSeen   = sel_sub;
                    j++;
                end
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        checkOutput({name, ":words_emitted"}, 32'(j), 32'd16);
        checkOutput({name, ":out_last_position"}, 32'(lastBad), 32'd0);
        checkOutput({name, ":sel_sub"}, 32'(selSeen), 32'(expSel));
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("%s:word%0d", name, k), 32'(resVec[k]), 32'(expVec[k]));

        lat = -1;
        for (int k = 0; k < 5; k++) begin
            if (done) begin
                lat = cycleCount - tStart;
                break;
            end
            @(negedge clk);
        end
        checkOutput({name, ":done_latency"}, 32'(lat), 32'(34 + inStallLen + outStallLen));
        @(negedge clk);
        checkOutput({name, ":done_pulse_end"}, 32'(done), 32'd0);
        checkOutput({name, ":idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        cycleCount = 0;
        clr        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        c_word     = 16'h0000;
        m_word     = 16'h0000;
        c_b256     = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset:busy", 32'(busy), 32'd0);
        checkOutput("reset:in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset:out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset:out_word", 32'(out_word), 32'd0);
        checkOutput("reset:out_last", 32'(out_last), 32'd0);
        checkOutput("reset:sel_sub", 32'(sel_sub), 32'd0);
        checkOutput("reset:done", 32'(done), 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // 5 - 3 = 2, no borrow out: subtract.
        clearVecs();
        cVec[0] = 16'h0005; mVec[0] = 16'h0003; expVec[0] = 16'h0002;
        applyStimulus("c5m3", 1'b0, -1, 0, -1, 0, 1'b1, -1);

        // 2 - 3 borrows out of the top: keep C.
        clearVecs();
        cVec[0] = 16'h0002; mVec[0] = 16'h0003; expVec[0] = 16'h0002;
        applyStimulus("c2m3", 1'b0, -1, 0, -1, 0, 1'b0, -1);

        // C == M: subtract, result zero.
        clearVecs();
        for (int k = 0; k < 16; k++) begin
            cVec[k] = 16'h1234; mVec[k] = 16'h1234;
        end
        applyStimulus("c_eq_m", 1'b0, -1, 0, -1, 0, 1'b1, -1);

        // 0x1_0000 - 1 = 0xFFFF across the word boundary.
        clearVecs();
        cVec[1] = 16'h0001; mVec[0] = 16'h0001; expVec[0] = 16'hFFFF;
        applyStimulus("borrow_chain", 1'b0, -1, 0, -1, 0, 1'b1, -1);

        // 2^256 - 1: borrow ripples through every word, b256 forces subtract.
        clearVecs();
        mVec[0] = 16'h0001;
        for (int k = 0; k < 16; k++) expVec[k] = 16'hFFFF;
        applyStimulus("b256", 1'b1, -1, 0, -1, 0, 1'b1, -1);

        // Distinct words: C[i] = 0x0100*i + 0x11, M = 0x10 -> 0x0100*i + 1.
        clearVecs();
        for (int k = 0; k < 16; k++) begin
            cVec[k]   = 16'(16'h0100 * k + 16'h0011);
            mVec[k]   = 16'h0010;
            expVec[k] = 16'(16'h0100 * k + 16'h0001);
        end
        applyStimulus("nostall", 1'b0, -1, 0, -1, 0, 1'b1, -1);
        applyStimulus("stall", 1'b0, 5, 2, 7, 3, 1'b1, -1);

        // Abort mid-load, then a clean run must still work.
        applyStimulus("abort", 1'b0, -1, 0, -1, 0, 1'b1, 9);
        clearVecs();
        cVec[0] = 16'h0005; mVec[0] = 16'h0003; expVec[0] = 16'h0002;
        applyStimulus("after_abort", 1'b0, -1, 0, -1, 0, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
